// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Main control FSM for a multicycle RISC-V subset datapath (lw, sw, R-type,
// I-type ALU, jal, beq). Each instruction walks FETCH -> DECODE -> one or more
// execute/memory states and returns to FETCH. Any unsupported opcode lands in
// a sticky ERROR state that only rst_n can clear.
//
// Build option:
//   MEM_HANDSHAKE_EN  When defined, FETCH, MEMREAD and MEMWRITE wait for
//                     mem_ready=1 before completing. A 4-bit wait counter
//                     counts non-ready cycles. After WAIT_MAX of them the FSM
//                     goes to ERROR. When undefined, mem_ready is ignored,
//                     those states take exactly one cycle, and no counter is
//                     built.
//
// Parameters:
//   WAIT_MAX    maximum number of non-ready cycles tolerated in one wait
//               state. Valid range is 1..16 because the counter is 4 bits.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset. State is forced to FETCH and
//               every enable is held low while rst_n is low.
//   op          7-bit opcode from the instruction register
//   zero        ALU zero flag, used for the beq decision
//   mem_ready   memory access complete (only used with MEM_HANDSHAKE_EN)
//   pc_write    PC load enable
//   adr_src     memory address select (0 = PC, 1 = ALU result). Also treated
//               as an enable and gated by reset.
//   mem_write   data memory write enable
//   ir_write    instruction register load enable
//   reg_write   register file write enable
//   alu_src_a   ALU operand A select
//   alu_src_b   ALU operand B select
//   result_src  result bus select
//   alu_op      ALU decoder control (00 add, 01 sub, 10 funct-decoded)
//   state       current state code
//   error       sticky fault flag. It is high in the ERROR state.
// -----------------------------------------------------------------------------
module multicycle_controller #(
    parameter int WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] alu_op,
    output logic [3:0] state,
    output logic       error
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_ERROR    = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t state_q;
    state_t state_d;

    // mem_done: the access in the current wait state finishes this cycle.
    // wait_expired: this cycle is the last allowed non-ready cycle.
    logic mem_done;
    logic wait_expired;

    // Enables before reset gating.
    logic pc_write_raw;
    logic adr_src_raw;
    logic mem_write_raw;
    logic ir_write_raw;
    logic reg_write_raw;

    // -------------------------------------------------------------------------
    // Memory handshake
    // -------------------------------------------------------------------------
`ifdef MEM_HANDSHAKE_EN
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_MAX - 1);

    logic [3:0] wait_cnt;
    logic       in_wait_state;

    assign in_wait_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                           (state_q == S_MEMWRITE);
    assign mem_done      = mem_ready;
    // The counter holds the number of non-ready cycles already spent. When
    // WAIT_LAST cycles have passed, this non-ready cycle is number WAIT_MAX
    // and it ends the wait.
    assign wait_expired  = in_wait_state && !mem_ready && (wait_cnt == WAIT_LAST);

    // The counter restarts whenever a wait state completes or the FSM is in a
    // state that does not wait, so each access gets the full budget.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (in_wait_state && !mem_ready && !wait_expired) begin
            wait_cnt <= wait_cnt + 4'd1;
        end else begin
            wait_cnt <= '0;
        end
    end
`else
    assign mem_done     = 1'b1;
    assign wait_expired = 1'b0;

    // mem_ready and WAIT_MAX only matter in the handshake build.
    logic unused_inputs;
    assign unused_inputs = mem_ready ^ (WAIT_MAX == 0);
`endif

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments. All flops then
    // sample their inputs at the same edge, whatever order the blocks run in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned in a combinational block gets a default
    // first. Without it, a path that skips the assignment would infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_done) begin
                    state_d = S_DECODE;
                end else if (wait_expired) begin
                    state_d = S_ERROR;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_LOAD,
                    OP_STORE:  state_d = S_MEMADR;
                    OP_RTYPE:  state_d = S_EXECR;
                    OP_ITYPE:  state_d = S_EXECI;
                    OP_JAL:    state_d = S_JAL;
                    OP_BRANCH: state_d = S_BEQ;
                    default:   state_d = S_ERROR;
                endcase
            end
            S_MEMADR: begin
                state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                if (mem_done) begin
                    state_d = S_MEMWB;
                end else if (wait_expired) begin
                    state_d = S_ERROR;
                end
            end
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: begin
                if (mem_done) begin
                    state_d = S_FETCH;
                end else if (wait_expired) begin
                    state_d = S_ERROR;
                end
            end
            S_EXECR,
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_ERROR:    state_d = S_ERROR;
            // Codes 11..14 are never entered. If one shows up, treat it as a
            // fault rather than wander.
            default:    state_d = S_ERROR;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic. Outputs depend on the state only, with two exceptions:
    // the beq zero term, and the handshake-qualified FETCH pulses.
    // -------------------------------------------------------------------------
    always_comb begin
        pc_write_raw  = 1'b0;
        adr_src_raw   = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        result_src    = 2'b00;
        alu_op        = 2'b00;
        error         = 1'b0;
        case (state_q)
            S_FETCH: begin
                // PC and IR load once, in the cycle the fetch completes.
                // The mux selects stay steady for the whole wait.
                ir_write_raw = mem_done;
                pc_write_raw = mem_done;
                alu_src_b    = 2'b10;
                result_src   = 2'b10;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                adr_src_raw = 1'b1;
            end
            S_MEMWB: begin
                result_src    = 2'b01;
                reg_write_raw = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src_raw   = 1'b1;
                mem_write_raw = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
            end
            S_BEQ: begin
                alu_src_a    = 2'b10;
                alu_op       = 2'b01;
                pc_write_raw = zero;
            end
            S_JAL: begin
                alu_src_a    = 2'b01;
                alu_src_b    = 2'b10;
                pc_write_raw = 1'b1;
            end
            S_ERROR: begin
                error = 1'b1;
            end
            default: begin
                error = 1'b1;
            end
        endcase
    end

    // The async reset already forces the state to FETCH. FETCH drives
    // pc_write/ir_write, so the enables are also gated with rst_n. This keeps
    // them low for the whole time rst_n is low, not just after a clock edge.
    assign pc_write  = pc_write_raw  & rst_n;
    assign adr_src   = adr_src_raw   & rst_n;
    assign mem_write = mem_write_raw & rst_n;
    assign ir_write  = ir_write_raw  & rst_n;
    assign reg_write = reg_write_raw & rst_n;

    assign state = state_q;

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have parameter WAIT_MAX, default 15, giving the maximum mem_ready wait cycles before the ERROR state.
REQ-002 The block SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-003 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port op, input, 7 bits, instruction opcode from the IR.
REQ-005 The block SHALL have port zero, input, 1 bit, ALU zero flag.
REQ-006 The block SHALL have port mem_ready, input, 1 bit, memory access complete.
REQ-007 The block SHALL have the following 1-bit outputs, each a register/PC/IR enable: pc_write, adr_src, mem_write, ir_write, reg_write.
REQ-008 The block SHALL have the following 2-bit outputs, each a mux select: alu_src_a, alu_src_b, result_src.
REQ-009 The block SHALL have port alu_op, output, 2 bits, to the ALU decoder (00 add, 01 sub, 10 funct-decoded).
REQ-010 The block SHALL have port state, output, 4 bits, current state code, and port error, output, 1 bit, sticky fault flag.

Function
REQ-011 The FSM SHALL use these states and codes: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, ERROR=15.
REQ-012 All outputs SHALL be Moore functions of the state, except pc_write, which also includes the BEQ zero term.
REQ-013 FETCH SHALL assert adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10 and pc_write=1, and go to DECODE on completion (REQ-025).
REQ-014 DECODE SHALL assert alu_src_a=01, alu_src_b=01, alu_op=00, then branch on op.
REQ-015 From DECODE: op 0000011 or 0100011 SHALL go to MEMADR; 0110011 to EXECR; 0010011 to EXECI; 1101111 to JAL; 1100011 to BEQ; any other op to ERROR.
REQ-016 MEMADR SHALL assert alu_src_a=10, alu_src_b=01, alu_op=00, then go to MEMREAD if op=0000011, else MEMWRITE.
REQ-017 MEMREAD SHALL assert result_src=00 and adr_src=1, and go to MEMWB on completion.
REQ-018 MEMWB SHALL assert result_src=01 and reg_write=1, then go to FETCH.
REQ-019 MEMWRITE SHALL assert result_src=00, adr_src=1 and mem_write=1, and go to FETCH on completion.
REQ-020 EXECR SHALL assert alu_src_a=10, alu_src_b=00, alu_op=10, then go to ALUWB; EXECI SHALL be identical except alu_src_b=01.
REQ-021 ALUWB SHALL assert result_src=00 and reg_write=1, then go to FETCH.
REQ-022 BEQ SHALL assert alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, pc_write=zero, then go to FETCH.
REQ-023 JAL SHALL assert alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1, then go to ALUWB.
REQ-024 In ERROR, all enables SHALL be 0 and error=1; ERROR SHALL be left only via reset.
REQ-025 "On completion" SHALL be per Configuration; enables SHALL stay asserted for every cycle of a FETCH, MEMREAD or MEMWRITE wait, except pc_write and ir_write, which SHALL pulse only in the completing cycle.
REQ-026 Unassigned outputs in any state SHALL be 0.

Reset
REQ-027 rst_n low SHALL asynchronously force state=FETCH, error=0, wait counter=0, with all enables 0 while rst_n is low.
REQ-028 Reset asserted mid-instruction SHALL abandon the instruction with no further write enable asserted.
REQ-029 After rst_n deasserts, the first rising edge SHALL evaluate FETCH normally.

Configuration
REQ-030 With MEM_HANDSHAKE_EN defined, FETCH/MEMREAD/MEMWRITE SHALL complete only in a cycle with mem_ready=1; a 4-bit wait counter SHALL increment per non-ready cycle, and reaching WAIT_MAX SHALL go to ERROR.
REQ-031 Without MEM_HANDSHAKE_EN, mem_ready SHALL be ignored, each of those states SHALL complete in exactly one cycle, and no counter SHALL exist.

Verification
REQ-032 Scenario: reset, then op=0110011 -> state sequence 0,1,6,8,0, with reg_write=1 only in the ALUWB cycle, alu_op=10 in EXECR; 4 cycles per instruction.
REQ-033 Scenario: op=1100011 with zero=1, then with zero=0 -> pc_write=1 in the BEQ cycle only in the first case; both take 3 cycles.
REQ-034 Scenario: op=0000011 with MEM_HANDSHAKE_EN and mem_ready low for 3 cycles in MEMREAD -> MEMREAD held for 4 cycles, then MEMWB with reg_write=1, result_src=01.
REQ-035 Scenario: op=1111111 -> DECODE goes to ERROR, error=1 held for 20 cycles, cleared by rst_n=0.
REQ-036 Scenario: with MEM_HANDSHAKE_EN, mem_ready held low in FETCH -> ERROR after exactly WAIT_MAX=15 wait cycles, with ir_write never asserted.
REQ-037 Scenario: rst_n pulsed low mid-MEMWRITE -> mem_write drops immediately and state=0 without a clock edge.
